// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, S-box, round-constant and GF(2^8) helpers
// Purpose: FSM state encoding, forward S-box table, RCON lookup and xtime
// used by the round cells, the key-step cell and the iterative controller.
package aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Round constant for expansion step rnd (1..10); 0 for anything else.
    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_add_round_key.sv
// rtl/aes_add_round_key.sv - AddRoundKey round cell
// Purpose: XORs the state with the round key.
// Ports: state_in[127:0], round_key[127:0] -> state_out[127:0], combinational.
module aes_add_round_key (
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);

    assign state_out = state_in ^ round_key;

endmodule

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one AES-128 key expansion step
// Purpose: derives the next round key from the current one.
// Ports: rk_in[127:0], rcon[7:0] -> rk_out[127:0], combinational, 4 S-box lookups.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk_in;

    // SubWord(RotWord(w3)) ^ {rcon, 24'h0}
    assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                ^ {rcon, 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_mix_columns.sv
// rtl/aes_mix_columns.sv - MixColumns round cell
// Purpose: multiplies each state column by the fixed {02,03,01,01} circulant matrix.
// Ports: state_in[127:0] -> state_out[127:0], combinational.
module aes_mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    output logic [127:0] state_out
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;

        assign {a0, a1, a2, a3} = state_in[127-32*c -: 32];

        // 3*a is xtime(a)^a
        assign b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

        assign state_out[127-32*c -: 32] = {b0, b1, b2, b3};
    end

endmodule

// File: rtl/aes_shift_rows.sv
// rtl/aes_shift_rows.sv - ShiftRows round cell
// Purpose: rotates row r of the column-major state left by r bytes.
// Ports: state_in[127:0] -> state_out[127:0], combinational; byte 0 = bits [127:120].
module aes_shift_rows (
    input  logic [127:0] state_in,
    output logic [127:0] state_out
);

    // Byte n sits at row n%4, column n/4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign state_out[127-8*(r+4*c) -: 8] = state_in[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end

endmodule

// File: rtl/aes_sub_bytes.sv
// rtl/aes_sub_bytes.sv - SubBytes round cell
// Purpose: applies the forward S-box to each of the 16 state bytes.
// Ports: state_in[127:0] -> state_out[127:0], combinational.
module aes_sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    output logic [127:0] state_out
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign state_out[8*i +: 8] = sbox(state_in[8*i +: 8]);
    end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// rtl/aes128_iter_ctrl.sv - iterative AES-128 encryption controller, one round per clock
// Purpose: accepts a plain/key pair on in_valid/in_ready, runs 10 rounds through one
// shared round datapath with on-the-fly key expansion, holds the ciphertext until
// out_ready.
// Ports: clk, rst (async, active-high); in_valid/in_ready with plain[127:0], key[127:0];
// out_valid/out_ready with cipher[127:0]; busy high while rounds are running.
module aes128_iter_ctrl
    import aes_pkg::*;
#(
    parameter int NR            = 10,
    parameter bit CLEAR_ON_IDLE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plain,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher,
    output logic         busy
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [7:0]   rcon_cur;
    logic [127:0] rk_next;
    logic [127:0] sb_out, sr_out, mc_out, mix_sel, ark_out;
    logic         rnd_ok;
    logic         last_rnd;

    // Round datapath
    assign rcon_cur = rcon_of(rnd_q);

    aes_key_step u_key_step (
        .rk_in  (rk_q),
        .rcon   (rcon_cur),
        .rk_out (rk_next)
    );

    aes_sub_bytes u_sub_bytes (
        .state_in  (state_q),
        .state_out (sb_out)
    );

    aes_shift_rows u_shift_rows (
        .state_in  (sb_out),
        .state_out (sr_out)
    );

    aes_mix_columns u_mix_columns (
        .state_in  (sr_out),
        .state_out (mc_out)
    );

    assign last_rnd = (rnd_q == LAST_RND);
    // Final round skips MixColumns.
    assign mix_sel  = last_rnd ? sr_out : mc_out;

    aes_add_round_key u_add_round_key (
        .state_in  (mix_sel),
        .round_key (rk_next),
        .state_out (ark_out)
    );

    assign rnd_ok = (rnd_q != 4'd0) && (rnd_q <= LAST_RND);

    // Next-state logic
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;

        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = plain ^ key;
                    rk_d    = key;
                    rnd_d   = 4'd1;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                if (!rnd_ok) begin
                    // Corrupted round counter: drop the block.
                    rnd_d = 4'd0;
                    fsm_d = S_IDLE;
                end else begin
                    state_d = ark_out;
                    rk_d    = rk_next;
                    if (last_rnd) begin
                        // Counter is only meaningful inside ROUND; park it at 0.
                        rnd_d = 4'd0;
                        fsm_d = S_DONE;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            rk_q    <= '0;
            rnd_q   <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
        end
    end

    // Handshake outputs are forced low while rst is asserted, not just after the edge.
    assign in_ready  = (fsm_q == S_IDLE)  && !rst;
    assign out_valid = (fsm_q == S_DONE)  && !rst;
    assign busy      = (fsm_q == S_ROUND) && !rst;
    assign cipher    = (CLEAR_ON_IDLE && !out_valid) ? 128'd0 : state_q;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// tb/tb_aes128_iter_ctrl.sv - scoreboard testbench for aes128_iter_ctrl
module tb_aes128_iter_ctrl;

    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [127:0] plain     = '0;
    logic [127:0] key       = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] cipher;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ready_mode = 0;
    int last_acc_edge = 0;
    int last_hs_edge  = 0;
    bit seen_valid = 1'b0;

    typedef struct {
        logic [127:0] exp;
        int           acc_edge;
    } exp_t;
    exp_t sbq[$];
    exp_t new_e;

    logic [7:0] sb [256];

    aes128_iter_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .plain     (plain),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cipher    (cipher),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: GF(2^8) arithmetic, S-box derived from inverse + affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] p, input logic [127:0] k);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++)
                        s[j+4*c] = t[j + 4*((c+j)%4)];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                        s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    s[j+4*c] = s[j+4*c] ^ w[4*r+c][31-8*j -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Monitor / scoreboard, sampling on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            chk_bit("rst_in_ready", in_ready, 1'b0);
            chk_bit("rst_out_valid", out_valid, 1'b0);
            chk_bit("rst_busy", busy, 1'b0);
            chk_vec("rst_cipher", cipher, 128'd0);
            sbq.delete();
            seen_valid = 1'b0;
        end else begin
            if (sbq.size() == 0) begin
                chk_bit("idle_in_ready", in_ready, 1'b1);
                chk_bit("idle_busy", busy, 1'b0);
                chk_bit("idle_out_valid", out_valid, 1'b0);
                chk_vec("idle_cipher", cipher, 128'd0);
            end else if (!out_valid) begin
                chk_bit("round_busy", busy, 1'b1);
                chk_bit("round_in_ready", in_ready, 1'b0);
                chk_vec("round_cipher", cipher, 128'd0);
                chk_bit("round_not_late", cyc < sbq[0].acc_edge + 10, 1'b1);
            end else begin
                chk_bit("done_busy", busy, 1'b0);
                chk_bit("done_in_ready", in_ready, 1'b0);
                if (!seen_valid) begin
                    chk_vec("latency", 128'(cyc - sbq[0].acc_edge), 128'd10);
                    seen_valid = 1'b1;
                end
                chk_vec("cipher", cipher, sbq[0].exp);
                if (out_ready) begin
                    void'(sbq.pop_front());
                    seen_valid   = 1'b0;
                    last_hs_edge = cyc + 1;
                end
            end
            if (in_valid && in_ready) begin
                new_e.exp      = model_encrypt(plain, key);
                new_e.acc_edge = cyc + 1;
                sbq.push_back(new_e);
                last_acc_edge  = cyc + 1;
            end
        end
    end

    // Consumer-side ready driver
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [127:0] p, input logic [127:0] k, input bit hold);
        int n;
        plain    = p;
        key      = k;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        chk_bit("send_accept_timeout", in_ready, 1'b1);
        step();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk_bit("wait_idle_timeout", n < 500, 1'b1);
        step();
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_bit("wait_valid_timeout", out_valid, 1'b1);
        step();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        build_sbox();
        chk_vec("model_kat_b", model_encrypt(PB, KB), CB);
        chk_vec("model_kat_c1", model_encrypt(PC, KC), CC);

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // FIPS-197 App. B
        send(PB, KB, 1'b0);
        wait_idle();

        // App. C.1 with input churn during rounds and 25 cycles of backpressure
        ready_mode = 1;
        send(PC, KC, 1'b0);
        for (int i = 0; i < 8; i++) begin
            plain    = rnd128();
            key      = rnd128();
            in_valid = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        wait_valid();
        for (int i = 0; i < 25; i++) begin
            in_valid = 1'b1;
            plain    = rnd128();
            key      = rnd128();
            step();
        end
        in_valid   = 1'b0;
        ready_mode = 0;
        wait_idle();

        // Reset during round 5, then a clean App. B
        send(PB, KB, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        send(PB, KB, 1'b0);
        wait_idle();

        // Back-to-back with in_valid held
        send(PB, KB, 1'b1);
        send(PC, KC, 1'b0);
        chk_vec("b2b_accept_gap", 128'(last_acc_edge - last_hs_edge), 128'd1);
        wait_idle();

        // Random pairs with random backpressure and gaps
        ready_mode = 2;
        for (int i = 0; i < 20; i++) begin
            send(rnd128(), rnd128(), 1'b0);
            repeat ($urandom_range(0, 14)) step();
        end
        ready_mode = 0;
        wait_idle();

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
